// File: rtl/lvds_rx_pkg.sv
// Shared types and constants for the LVDS_EXT receive deserializer.
// The optional LVDS_RX_ERR_CNT_EN build adds a running invalid-bit counter
// whose width is defined here.
package lvds_rx_pkg;

   // Alignment state of the receiver
   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   // Default comma/sync word for a 10-bit link
   localparam logic [9:0] SYNC_WORD_DEF = 10'b1111100000;

   // Width of the optional total invalid-bit counter
   localparam int ERR_CNT_W = 16;

   // A differential pair is unresolvable when both legs agree
   function automatic logic pair_invalid(input logic [1:0] pair);
      return (pair[1] == pair[0]);
   endfunction

endpackage

// File: rtl/lvds_rx_diff_sync.sv
// Two-flop capture of the I/IB pad pair followed by resolution to one bit.
// An unresolvable pair (00/11) repeats the last resolved bit and raises
// rx_invalid. The reset contents of the capture flops are not line samples,
// so until both stages hold real samples the output simply repeats the last
// bit without being flagged.
module lvds_rx_diff_sync
   import lvds_rx_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i,
   input  logic ib,
   output logic rx_bit,
   output logic rx_invalid
);

   logic [1:0] pair1_r;
   logic [1:0] pair2_r;
   logic [1:0] fill_r;
   logic       last_bit_r;

   // Capture the pad pair through two stages and remember the last resolved bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair1_r    <= 2'b00;
         pair2_r    <= 2'b00;
         fill_r     <= 2'b00;
         last_bit_r <= 1'b0;
      end else begin
         pair1_r    <= {i, ib};
         pair2_r    <= pair1_r;
         fill_r     <= {fill_r[0], 1'b1};
         last_bit_r <= rx_bit;
      end
   end

   // Resolve the second-stage pair, holding the last bit when it is unusable
   always_comb begin
      rx_bit     = last_bit_r;
      rx_invalid = 1'b0;
      if (!fill_r[1]) begin
         rx_bit     = last_bit_r;
         rx_invalid = 1'b0;
      end else if (pair_invalid(pair2_r)) begin
         rx_bit     = last_bit_r;
         rx_invalid = 1'b1;
      end else begin
         rx_bit     = pair2_r[1];
         rx_invalid = 1'b0;
      end
   end

endmodule

// File: rtl/lvds_ext_deser_rx.sv
// LVDS_EXT receive deserializer: hunts for SYNC_WORD, then emits WIDTH-bit
// words MSB-first with a one-cycle valid strobe. ERR_MAX consecutive invalid
// differential bits drop lock and restart the hunt.
// Optional feature macro: LVDS_RX_ERR_CNT_EN adds the err_cnt output, a
// saturating count of every invalid bit since reset.
module lvds_ext_deser_rx
   import lvds_rx_pkg::*;
#(
   parameter int               WIDTH     = 10,
   parameter logic [WIDTH-1:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter int               ERR_MAX   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i,
   input  logic             ib,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             lock,
   output logic             diff_err
`ifdef LVDS_RX_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int EW  = $clog2(ERR_MAX + 1);

   localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
   localparam logic [EW-1:0]  ERR_TOP  = EW'(ERR_MAX);

   logic             rx_bit_s;
   logic             rx_invalid_s;
   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_nxt_s;
   logic [EW-1:0]    err_r;
   logic [EW-1:0]    err_nxt_s;
   logic [BCW-1:0]   bit_cnt_r;
   state_e           state_r;
   logic             sync_hit_s;
   logic             err_hit_s;

   lvds_rx_diff_sync u_diff_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .i          (i),
      .ib         (ib),
      .rx_bit     (rx_bit_s),
      .rx_invalid (rx_invalid_s)
   );

   // Next shift-register contents and next consecutive-error count
   always_comb begin
      shift_nxt_s = {shift_r[WIDTH-2:0], rx_bit_s};
      err_nxt_s   = EW'(0);
      if (rx_invalid_s) begin
         if (err_r == ERR_TOP) begin
            err_nxt_s = err_r;
         end else begin
            err_nxt_s = err_r + EW'(1);
         end
      end else begin
         err_nxt_s = EW'(0);
      end
      sync_hit_s = (shift_nxt_s == SYNC_WORD);
      err_hit_s  = (err_nxt_s == ERR_TOP);
   end

   // Shift one resolved bit per cycle, track error run, flag invalid bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r  <= '0;
         err_r    <= EW'(0);
         diff_err <= 1'b0;
      end else begin
         shift_r  <= shift_nxt_s;
         err_r    <= err_nxt_s;
         diff_err <= rx_invalid_s;
      end
   end

   // Alignment FSM with word counter and registered data/valid/lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= HUNT;
         bit_cnt_r <= BCW'(0);
         data      <= '0;
         valid     <= 1'b0;
         lock      <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state_r)
            HUNT: begin
               bit_cnt_r <= BCW'(0);
               if (sync_hit_s) begin
                  state_r <= LOCKED;
                  lock    <= 1'b1;
               end else begin
                  state_r <= HUNT;
                  lock    <= 1'b0;
               end
            end
            LOCKED: begin
               if (err_hit_s) begin
                  // Lock loss takes priority over a word completing on this edge
                  state_r   <= HUNT;
                  lock      <= 1'b0;
                  bit_cnt_r <= BCW'(0);
               end else begin
                  lock <= 1'b1;
                  if (bit_cnt_r == LAST_BIT) begin
                     data      <= shift_nxt_s;
                     valid     <= 1'b1;
                     bit_cnt_r <= BCW'(0);
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BCW'(1);
                  end
               end
            end
            default: begin
               state_r   <= HUNT;
               lock      <= 1'b0;
               bit_cnt_r <= BCW'(0);
            end
         endcase
      end
   end

`ifdef LVDS_RX_ERR_CNT_EN
   // Saturating total of invalid bits since reset, independent of lock state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= ERR_CNT_W'(0);
      end else begin
         if (rx_invalid_s && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end else begin
            err_cnt <= err_cnt;
         end
      end
   end
`endif

endmodule
